// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants for the fetch unit: address field positions, PCLATH page
// bits, default widths and the PC source selector.
package pc_fetch_unit_pkg;

    localparam int            PFU_PC_WIDTH    = 13;
    localparam int            PFU_STACK_DEPTH = 8;
    localparam int            PFU_INSTR_WIDTH = 14;
    localparam logic [13:0]   PFU_NOP_WORD    = 14'h0000;

    // goto/call carry an 11-bit target; the upper two bits come from PCLATH
    localparam int            ADDR_FIELD_MSB  = 10;
    localparam int            PAGE_HI         = 4;
    localparam int            PAGE_LO         = 3;

    typedef enum logic [2:0] {
        PC_HOLD,
        PC_INCR,
        PC_PCL,
        PC_JUMP,
        PC_RET
    } pc_sel_e;

    function automatic pc_sel_e pc_select(
        input logic ret,
        input logic call,
        input logic jmp,
        input logic pcl,
        input logic incr
    );
        if (ret)              return PC_RET;
        else if (call || jmp) return PC_JUMP;
        else if (pcl)         return PC_PCL;
        else if (incr)        return PC_INCR;
        else                  return PC_HOLD;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_return_stack.sv
// Circular return-address stack with saturating occupancy and sticky
// overflow/underflow flags. Pop takes priority over a simultaneous push.
module return_stack #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             overflow,
    output logic             underflow
);

    localparam int         PW   = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    sp_q;
    logic [PW-1:0]    sp_m1;
    logic [PW:0]      occ_q;
    logic             ovf_q;
    logic             unf_q;

    assign sp_m1     = sp_q - 1'b1;
    assign dout      = mem_q[sp_m1];
    assign overflow  = ovf_q;
    assign underflow = unf_q;

    // Entries are not reset: an empty pop deliberately returns stale data.
    always_ff @(posedge clk) begin
        if (push && !pop) mem_q[sp_q] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp_q  <= '0;
            occ_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (pop) begin
            sp_q <= sp_m1;
            if (occ_q == '0) unf_q <= 1'b1;
            else             occ_q <= occ_q - 1'b1;
        end else if (push) begin
            sp_q <= sp_q + 1'b1;
            if (occ_q == FULL) ovf_q <= 1'b1;
            else               occ_q <= occ_q + 1'b1;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter, instruction register and return stack feeding the decoder.
// prog_data reaches outputs only through the registered instr_current.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int          PC_WIDTH    = PFU_PC_WIDTH,
    parameter int          STACK_DEPTH = PFU_STACK_DEPTH,
    parameter logic [13:0] NOP_WORD    = PFU_NOP_WORD
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                instr_rd_en,
    input  logic                instr_flush,
    input  logic                pc_incr_en,
    input  logic                pc_j_en,
    input  logic                pc_call_en,
    input  logic                pc_ret_en,
    input  logic                pcl_wr_en,
    input  logic [7:0]          pcl_wr_data,
    input  logic [4:0]          pclath,
    output logic [PC_WIDTH-1:0] prog_addr,
    input  logic [13:0]         prog_data,
    output logic [13:0]         instr_current,
    output logic [PC_WIDTH-1:0] pc,
    output logic                stack_overflow,
    output logic                stack_underflow
);

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [13:0]         ir_q, ir_d;
    logic [PC_WIDTH-1:0] stack_top;
    logic [PC_WIDTH-1:0] jump_tgt;
    logic [PC_WIDTH-1:0] pcl_tgt;
    pc_sel_e             pc_sel;

    assign jump_tgt = PC_WIDTH'({pclath[PAGE_HI:PAGE_LO], ir_q[ADDR_FIELD_MSB:0]});
    assign pcl_tgt  = PC_WIDTH'({pclath, pcl_wr_data});
    assign pc_sel   = pc_select(pc_ret_en, pc_call_en, pc_j_en, pcl_wr_en, pc_incr_en);

    always_comb begin
        pc_d = pc_q;
        unique case (pc_sel)
            PC_RET:  pc_d = stack_top;
            PC_JUMP: pc_d = jump_tgt;
            PC_PCL:  pc_d = pcl_tgt;
            PC_INCR: pc_d = pc_q + 1'b1;
            default: pc_d = pc_q;
        endcase
    end

    // Flush beats read so a skipped or jumped-over word never reaches decode.
    always_comb begin
        ir_d = ir_q;
        if (instr_flush)      ir_d = NOP_WORD;
        else if (instr_rd_en) ir_d = prog_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= '0;
            ir_q <= NOP_WORD;
        end else begin
            pc_q <= pc_d;
            ir_q <= ir_d;
        end
    end

    // A call colliding with a return is suppressed so the return wins cleanly.
    return_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pc_call_en & ~pc_ret_en),
        .pop       (pc_ret_en),
        .din       (pc_q),
        .dout      (stack_top),
        .overflow  (stack_overflow),
        .underflow (stack_underflow)
    );

    assign prog_addr     = pc_q;
    assign pc            = pc_q;
    assign instr_current = ir_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: each stimulus step queues its expected
// post-edge state, a monitor checks it just after the clock edge.
module tb_pc_fetch_unit;

    typedef struct packed {
        logic [12:0] pc;
        logic [13:0] ir;
        logic        ovf;
        logic        unf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_rd_en, instr_flush, pc_incr_en, pc_j_en;
    logic        pc_call_en, pc_ret_en, pcl_wr_en;
    logic [7:0]  pcl_wr_data;
    logic [4:0]  pclath;
    logic [12:0] prog_addr;
    logic [13:0] prog_data;
    logic [13:0] instr_current;
    logic [12:0] pc;
    logic        stack_overflow, stack_underflow;

    exp_t        exp_q[$];
    string       name_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [13:0] e_ir;
    logic        e_o, e_u;

    always #5 clk = ~clk;

    function automatic logic [13:0] pmem(input logic [12:0] a);
        case (a)
            13'd0:   return 14'h3005;
            13'd7:   return 14'h2ABC;
            default: return {1'b0, a} ^ 14'h1555;
        endcase
    endfunction

    assign prog_data = pmem(prog_addr);

    pc_fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .instr_rd_en     (instr_rd_en),
        .instr_flush     (instr_flush),
        .pc_incr_en      (pc_incr_en),
        .pc_j_en         (pc_j_en),
        .pc_call_en      (pc_call_en),
        .pc_ret_en       (pc_ret_en),
        .pcl_wr_en       (pcl_wr_en),
        .pcl_wr_data     (pcl_wr_data),
        .pclath          (pclath),
        .prog_addr       (prog_addr),
        .prog_data       (prog_data),
        .instr_current   (instr_current),
        .pc              (pc),
        .stack_overflow  (stack_overflow),
        .stack_underflow (stack_underflow)
    );

    task automatic clear_strobes();
        instr_rd_en = 0; instr_flush = 0; pc_incr_en = 0; pc_j_en = 0;
        pc_call_en  = 0; pc_ret_en   = 0; pcl_wr_en  = 0;
    endtask

    // Queue the expected state after the coming edge, then advance one cycle.
    task automatic tick(input string nm, input logic [12:0] epc);
        exp_t e;
        e.pc = epc; e.ir = e_ir; e.ovf = e_o; e.unf = e_u;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        @(negedge clk);
        clear_strobes();
    endtask

    task automatic set_pc(input logic [4:0] lath, input logic [7:0] d, input logic [12:0] epc);
        pclath = lath; pcl_wr_data = d; pcl_wr_en = 1;
        tick("set_pc", epc);
    endtask

    initial begin : monitor
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                total++;
                if (pc !== e.pc || prog_addr !== e.pc || instr_current !== e.ir ||
                    stack_overflow !== e.ovf || stack_underflow !== e.unf) begin
                    bad++;
                    $display("FAIL %s: got pc=%h addr=%h ir=%h ovf=%b unf=%b, want pc=%h ir=%h ovf=%b unf=%b",
                             nm, pc, prog_addr, instr_current, stack_overflow, stack_underflow,
                             e.pc, e.ir, e.ovf, e.unf);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin : stim
        rst_n = 0; clear_strobes();
        pclath = 0; pcl_wr_data = 0;
        e_ir = 14'h0000; e_o = 0; e_u = 0;
        @(negedge clk);
        tick("reset", 13'h0000);

        rst_n = 1;
        pc_incr_en = 1; instr_rd_en = 1; e_ir = 14'h3005;
        tick("fetch0", 13'h0001);

        set_pc(5'h1F, 8'hFF, 13'h1FFF);
        pc_incr_en = 1;
        tick("pc_wrap", 13'h0000);

        pclath = 5'h00; pcl_wr_data = 8'h05; pcl_wr_en = 1; pc_incr_en = 1;
        tick("pcl_beats_incr", 13'h0005);

        instr_flush = 1; instr_rd_en = 1; pc_incr_en = 1; e_ir = 14'h0000;
        tick("skip", 13'h0006);
        pc_incr_en = 1;
        tick("incr", 13'h0007);
        instr_rd_en = 1; e_ir = 14'h2ABC;
        tick("load_goto", 13'h0007);
        pclath = 5'h18; pc_j_en = 1; instr_flush = 1; e_ir = 14'h0000;
        tick("goto", 13'h1ABC);

        // Eight calls then eight returns; call target is page 0 offset 0.
        for (int k = 1; k <= 8; k++) begin
            set_pc(5'h00, 8'(k), 13'(k));
            pc_call_en = 1;
            tick("call", 13'h0000);
        end
        for (int k = 8; k >= 1; k--) begin
            pc_ret_en = 1;
            tick("ret", 13'(k));
        end

        for (int k = 1; k <= 9; k++) begin
            set_pc(5'h00, 8'(k), 13'(k));
            pc_call_en = 1;
            if (k == 9) e_o = 1;
            tick("call9", 13'h0000);
        end
        pc_ret_en = 1;
        tick("ret_ninth", 13'd9);
        for (int k = 8; k >= 2; k--) begin
            pc_ret_en = 1;
            tick("ret_drain", 13'(k));
        end
        pc_ret_en = 1; e_u = 1;
        tick("ret_empty_stale", 13'd9);

        pclath = 5'h03; pcl_wr_data = 8'h40; pcl_wr_en = 1; pc_incr_en = 1;
        tick("pcl_0340", 13'h0340);
        rst_n = 0; pc_incr_en = 1; pc_call_en = 1; instr_rd_en = 1;
        e_ir = 14'h0000; e_o = 0; e_u = 0;
        tick("mid_reset", 13'h0000);
        rst_n = 1;

        // Call together with return: return wins and nothing is pushed.
        set_pc(5'h00, 8'h20, 13'h0020);
        pc_call_en = 1;
        tick("call_a", 13'h0000);
        set_pc(5'h00, 8'h30, 13'h0030);
        pc_call_en = 1; pc_ret_en = 1;
        tick("call_ret_clash", 13'h0020);
        pc_ret_en = 1; e_u = 1;
        tick("no_push_on_clash", 13'h0008);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Upstream neighbour of the instruction decoder: owns the program counter, the 8-level return stack and the instruction register (instr_current).
- Drives the program-memory address and latches the fetched word.
- Acts on the decoder's four per-instruction strobes (instr_rd_en, instr_flush, pc_incr_en, pc_j_en), plus call/return strobes and PCL writes from the register file.

Parameters:
PC_WIDTH, 13, program counter / program memory address width
STACK_DEPTH, 8, return stack entries (power of two)
NOP_WORD, 14'h0000, word loaded into instr_current on flush and reset

Ports:
clk  in  1  system clock; all state changes on rising edge
rst_n  in  1  reset, synchronous, active-low
instr_rd_en  in  1  load instr_current from prog_data this edge
instr_flush  in  1  load NOP_WORD into instr_current this edge
pc_incr_en  in  1  PC <= PC+1
pc_j_en  in  1  goto: PC <= {pclath[4:3], instr_current[10:0]}
pc_call_en  in  1  call: push PC, then jump as pc_j_en
pc_ret_en  in  1  return: PC <= popped value
pcl_wr_en  in  1  register-file write to PCL
pcl_wr_data  in  8  data for PCL write
pclath  in  5  PCLATH register contents
prog_addr  out  PC_WIDTH  program memory address (= PC)
prog_data  in  14  program memory word (asynchronous read of prog_addr)
instr_current  out  14  instruction register, feeds decoder
pc  out  PC_WIDTH  current PC
stack_overflow  out  1  sticky: push while full
stack_underflow  out  1  sticky: pop while empty

Behaviour:
- Reset (rst_n=0 at edge):
  - PC=0, instr_current=NOP_WORD.
  - Stack pointer=0, occupancy=0.
  - Both stack flags=0.
  - Reset wins over every strobe, mid-instruction included.
- PC semantics: PC always holds the address of the next word to fetch. prog_addr=PC combinationally.
- After reset the decoder sees a NOP. At its Q3 edge instr_current<=mem[0] and PC=1.
- Instruction register update, per edge, in priority order:
  1. instr_flush=1 → NOP_WORD. Flush wins over a simultaneous rd_en.
  2. instr_rd_en=1 → prog_data, sampled with prog_addr = PC before the update.
  3. Otherwise hold.
- PC update, per edge, in priority order:
  1. pc_ret_en → top of stack.
  2. pc_call_en or pc_j_en → {pclath[4:3], instr_current[10:0]}.
  3. pcl_wr_en → {pclath[4:0], pcl_wr_data}.
  4. pc_incr_en → PC+1, modulo 2^PC_WIDTH (0x1FFF wraps to 0x0000).
  5. Otherwise hold.
- Skip instructions: pc_incr_en with instr_flush advances PC past the skipped word while the IR becomes NOP. A two-cycle skip results.
- Jump latency: goto, call and return assert flush in the same edge. The target word is fetched at the next instruction's Q3, giving 8 clocks total.
- Return stack:
  - Circular buffer of STACK_DEPTH×PC_WIDTH.
  - Push stores current PC (the return address) at sp, then sp<=sp+1 (mod depth).
  - Pop: sp<=sp-1, output entry[sp-1].
  - Pushing a 9th entry overwrites the oldest and sets stack_overflow.
  - Popping empty wraps sp and returns the stale entry; stack_underflow is set.
  - Occupancy saturates at 0 and STACK_DEPTH.
  - Flags clear only on reset.
- Simultaneous pc_call_en and pc_ret_en is illegal. Required behaviour: return has priority and no push occurs.
- Simultaneous pcl_wr_en and pc_incr_en: the PCL write wins. The increment is not applied on top.
- No combinational path from prog_data to any output except through instr_current.

Decomposition:
- Shared package (extend isa.vh): NOP_WORD, goto/call address-field positions [10:0], PCLATH page bit positions [4:3], PC_WIDTH.
- One sub-module: return_stack.
  - Ports: clk, rst_n, push, pop, din, dout, overflow, underflow.
  - Contents: the circular buffer and sticky flags.
- pc_fetch_unit contains the PC/IR registers and the priority muxes.

Test Plan:
- Reset, then hold pc_incr_en=instr_rd_en=1 for one edge with mem[0]=14'h3005 → instr_current=14'h3005, pc=1.
- PC=13'h1FFF, pc_incr_en → pc=13'h0000.
- instr_flush=instr_rd_en=pc_incr_en=1 at PC=5 → instr_current=14'h0000, pc=6.
- Goto with instr_current=14'h2ABC, pclath=5'h18, pc_j_en+flush → pc=13'h1ABC, instr_current=NOP.
- Return stack:
  - 8 calls from PCs 1..8 then 8 returns → pops 8..1, no flags.
  - 9th call sets stack_overflow=1 and a later return yields the 9th address.
  - A pop from empty sets stack_underflow.
- pcl_wr_en with pcl_wr_data=8'h40, pclath=5'h03, plus pc_incr_en; then rst_n=0 mid-sequence → first pc=13'h0340; after reset pc=0, instr_current=NOP, flags=0.
